// File: rtl/lsu_result_fifo.sv
// lsu_result_fifo: aligns and extends LSU load data, then buffers results in a circular FIFO toward writeback
module lsu_result_fifo #(
  parameter int DEPTH    = 4,
  parameter int PTR_LEN  = $clog2(DEPTH),
  parameter int ROB_ID_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         in_rdata_i,
  input  logic [ROB_ID_W-1:0] in_wid_i,
  input  logic [1:0]          in_vaddr_lo_i,
  input  logic [1:0]          in_msize_i,
  input  logic                in_msigned_i,
  input  logic                in_is_load_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_data_o,
  output logic [ROB_ID_W-1:0] out_wid_o,
  output logic                out_wen_o,
  output logic                out_misalign_o
);
  localparam int CNT_W = PTR_LEN + 1;
  logic [31:0]         data_q [DEPTH];
  logic [ROB_ID_W-1:0] wid_q  [DEPTH];
  logic                wen_q  [DEPTH];
  logic                mis_q  [DEPTH];
  logic [PTR_LEN-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         lane, ext, data_in;
  logic                mis, wen_in, push, pop;
  // align the addressed lane, extend it, and flag misaligned halves/words
  always_comb begin
    lane    = in_rdata_i >> {in_vaddr_lo_i, 3'b000};
    ext     = (in_msize_i == 2'd0) ? {{24{in_msigned_i & lane[7]}}, lane[7:0]} :
              (in_msize_i == 2'd1) ? {{16{in_msigned_i & lane[15]}}, lane[15:0]} : lane;
    mis     = ((in_msize_i == 2'd1) & in_vaddr_lo_i[0]) | (in_msize_i[1] & (|in_vaddr_lo_i));
    wen_in  = in_is_load_i & ~mis;
    data_in = wen_in ? ext : 32'd0;
  end
  assign in_ready_o     = count_q != CNT_W'(DEPTH);
  assign out_valid_o    = count_q != '0;
  assign push           = in_valid_i & in_ready_o;
  assign pop            = out_valid_o & out_ready_i;
  assign out_data_o     = data_q[head_q];
  assign out_wid_o      = wid_q[head_q];
  assign out_wen_o      = wen_q[head_q];
  assign out_misalign_o = mis_q[head_q];
  // pointer/count next state; flush discards everything and ignores same-cycle push/pop
  always_comb begin
    head_d  = flush ? '0 : pop ? head_q + 1'b1 : head_q;
    tail_d  = flush ? '0 : push ? tail_q + 1'b1 : tail_q;
    count_d = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
  end
  // pointer/count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // payload write at tail; payload needs no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push & ~flush & ~rst) begin
      data_q[tail_q] <= data_in;
      wid_q[tail_q]  <= in_wid_i;
      wen_q[tail_q]  <= wen_in;
      mis_q[tail_q]  <= mis;
    end
  end
endmodule

// File: tb/tb_lsu_result_fifo.sv
// tb_lsu_result_fifo: directed vectors with hand-computed expectations for lsu_result_fifo
module tb_lsu_result_fifo;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid_i, in_ready_o, in_msigned_i, in_is_load_i;
  logic [31:0] in_rdata_i, out_data_o;
  logic [5:0]  in_wid_i, out_wid_o;
  logic [1:0]  in_vaddr_lo_i, in_msize_i;
  logic        out_valid_o, out_ready_i, out_wen_o, out_misalign_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  lsu_result_fifo #(.DEPTH(4), .ROB_ID_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata_i),
    .in_wid_i(in_wid_i), .in_vaddr_lo_i(in_vaddr_lo_i), .in_msize_i(in_msize_i),
    .in_msigned_i(in_msigned_i), .in_is_load_i(in_is_load_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_wid_o(out_wid_o), .out_wen_o(out_wen_o), .out_misalign_o(out_misalign_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] rd, input logic [1:0] lo, input logic [1:0] sz,
                       input logic sg, input logic ld, input logic [5:0] wid);
    in_valid_i = v; in_rdata_i = rd; in_vaddr_lo_i = lo; in_msize_i = sz;
    in_msigned_i = sg; in_is_load_i = ld; in_wid_i = wid;
  endtask
  task automatic head(input string tag, input logic [31:0] d, input logic [5:0] wid, input logic wen, input logic mis);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, "_data"}, out_data_o, d);
    check({tag, "_wid"}, 32'(out_wid_o), 32'(wid));
    check({tag, "_wen"}, 32'(out_wen_o), 32'(wen));
    check({tag, "_mis"}, 32'(out_misalign_o), 32'(mis));
  endtask
  task automatic single(input string tag, input logic [31:0] rd, input logic [1:0] lo, input logic [1:0] sz,
                        input logic sg, input logic ld, input logic [5:0] wid,
                        input logic [31:0] d, input logic wen, input logic mis);
    out_ready_i = 1'b0;
    drive(1'b1, rd, lo, sz, sg, ld, wid);
    step();
    in_valid_i = 1'b0;
    head(tag, d, wid, wen, mis);
    out_ready_i = 1'b1;
    step();
    check({tag, "_drained"}, 32'(out_valid_o), 32'd0);
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 6'd0);
    step(); step();
    rst = 1'b0;
    check("rst_ready", 32'(in_ready_o), 32'd1);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    single("sbyte", 32'h80FF_7F01, 2'd3, 2'd0, 1'b1, 1'b1, 6'd1, 32'hFFFF_FF80, 1'b1, 1'b0);
    single("ubyte", 32'h80FF_7F01, 2'd1, 2'd0, 1'b0, 1'b1, 6'd2, 32'h0000_007F, 1'b1, 1'b0);
    single("uhalf", 32'hBEEF_1234, 2'd2, 2'd1, 1'b0, 1'b1, 6'd3, 32'h0000_BEEF, 1'b1, 1'b0);
    single("shalf", 32'h0000_8001, 2'd0, 2'd1, 1'b1, 1'b1, 6'd4, 32'hFFFF_8001, 1'b1, 1'b0);
    single("misword", 32'hBEEF_1234, 2'd1, 2'd2, 1'b0, 1'b1, 6'd5, 32'h0, 1'b0, 1'b1);
    single("mishalf", 32'hBEEF_1234, 2'd3, 2'd1, 1'b1, 1'b1, 6'd6, 32'h0, 1'b0, 1'b1);
    single("msize3", 32'hCAFE_F00D, 2'd0, 2'd3, 1'b1, 1'b1, 6'd7, 32'hCAFE_F00D, 1'b1, 1'b0);
    single("store", 32'hCAFE_F00D, 2'd0, 2'd2, 1'b0, 1'b0, 6'd8, 32'h0, 1'b0, 1'b0);
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 2'd0, 2'd2, 1'b0, 1'b1, 6'(i));
      step();
    end
    check("full_ready", 32'(in_ready_o), 32'd0);
    drive(1'b1, 32'h1005, 2'd0, 2'd2, 1'b0, 1'b1, 6'd5);
    step();
    in_valid_i = 1'b0;
    check("full_ready_hold", 32'(in_ready_o), 32'd0);
    head("full_hold", 32'h1001, 6'd1, 1'b1, 1'b0);
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      head($sformatf("drain%0d", i), 32'h1000 + 32'(i), 6'(i), 1'b1, 1'b0);
      step();
    end
    check("drain_empty", 32'(out_valid_o), 32'd0);
    check("drain_ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b0;
    drive(1'b1, 32'h2000, 2'd0, 2'd2, 1'b0, 1'b1, 6'd10);
    step();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 32'h2000 + 32'(i), 2'd0, 2'd2, 1'b0, 1'b1, 6'(10 + i));
      check($sformatf("wrap_rdy%0d", i), 32'(in_ready_o), 32'd1);
      head($sformatf("wrap%0d", i), 32'h2000 + 32'(i - 1), 6'(9 + i), 1'b1, 1'b0);
      step();
    end
    in_valid_i = 1'b0;
    head("wrap_last", 32'h2009, 6'd19, 1'b1, 1'b0);
    step();
    check("wrap_empty", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(i), 2'd0, 2'd2, 1'b0, 1'b1, 6'(20 + i));
      step();
    end
    drive(1'b1, 32'h3003, 2'd0, 2'd2, 1'b0, 1'b1, 6'd23);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid_i = 1'b0;
    check("flush_valid", 32'(out_valid_o), 32'd0);
    check("flush_ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b1;
    step(); step();
    check("flush_nostale", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h4000 + 32'(i), 2'd0, 2'd2, 1'b0, 1'b1, 6'(30 + i));
      step();
    end
    in_valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_valid", 32'(out_valid_o), 32'd0);
    check("rst2_ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b1;
    step();
    check("rst2_nostale", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
    drive(1'b1, 32'h4002, 2'd0, 2'd2, 1'b0, 1'b1, 6'd32);
    step();
    in_valid_i = 1'b0;
    head("rst2_fresh", 32'h4002, 6'd32, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
